// File: rtl/usb_rx_eop_detect_if.sv
// USB full-speed RX EOP detector bus.
// Line inputs from synchronisers, EOP status out to RX control.
`timescale 1ns/1ps
interface usb_rx_eop_detect_if #(
  parameter int CNT_W = 3
);
  logic             d_plus_sync;
  logic             d_minus_sync;
  logic             shift_en;
  logic             eop;
  logic             in_eop;
  logic             eop_valid;
  logic             eop_err;
  logic [CNT_W-1:0] se0_cnt;

  modport master (
    output d_plus_sync,
    output d_minus_sync,
    output shift_en,
    input  eop,
    input  in_eop,
    input  eop_valid,
    input  eop_err,
    input  se0_cnt
  );

  modport slave (
    input  d_plus_sync,
    input  d_minus_sync,
    input  shift_en,
    output eop,
    output in_eop,
    output eop_valid,
    output eop_err,
    output se0_cnt
  );
endinterface

// File: rtl/usb_rx_eop_detect.sv
// USB full-speed RX end-of-packet detector.
// Counts strobed SE0 bit-times, then requires a J trailer.
`timescale 1ns/1ps
module usb_rx_eop_detect #(
  parameter int SE0_MIN = 2,
  parameter int SE0_MAX = 4,
  parameter int J_BITS  = 1,
  parameter int CNT_W   = $clog2(SE0_MAX+1)
) (
  input logic               clk,
  input logic               n_rst,
  usb_rx_eop_detect_if.slave bus
);

  localparam int JW = (J_BITS > 1) ? $clog2(J_BITS+1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SE0,
    J_CHK,
    DONE,
    ERR
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] se0_cnt_q, se0_cnt_d;
  logic [JW-1:0]    j_cnt_q, j_cnt_d;
  logic             in_eop_q;
  logic             valid_q;
  logic             err_q;

  logic ln_se0, ln_j, ln_k, ln_se1;

  assign ln_se0 = ~bus.d_plus_sync & ~bus.d_minus_sync;
  assign ln_j   =  bus.d_plus_sync & ~bus.d_minus_sync;
  assign ln_k   = ~bus.d_plus_sync &  bus.d_minus_sync;
  assign ln_se1 =  bus.d_plus_sync &  bus.d_minus_sync;

  assign bus.eop       = ln_se0;
  assign bus.in_eop    = in_eop_q;
  assign bus.eop_valid = valid_q;
  assign bus.eop_err   = err_q;
  assign bus.se0_cnt   = se0_cnt_q;

  always_comb begin
    state_d   = state_q;
    se0_cnt_d = se0_cnt_q;
    j_cnt_d   = j_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.shift_en && ln_se0) begin
          state_d   = SE0;
          se0_cnt_d = CNT_W'(1);
        end
      end
      SE0: begin
        if (bus.shift_en) begin
          unique case (1'b1)
            ln_se0: begin
              if (se0_cnt_q + CNT_W'(1) >= CNT_W'(SE0_MAX)) begin
                state_d   = ERR;
                se0_cnt_d = CNT_W'(SE0_MAX);
              end else begin
                se0_cnt_d = se0_cnt_q + CNT_W'(1);
              end
            end
            ln_j: begin
              if (se0_cnt_q < CNT_W'(SE0_MIN)) begin
                state_d = ERR;
              end else if (J_BITS == 1) begin
                state_d = DONE;
              end else begin
                state_d = J_CHK;
                j_cnt_d = JW'(1);
              end
            end
            ln_k, ln_se1: state_d = ERR;
          endcase
        end
      end
      J_CHK: begin
        if (bus.shift_en) begin
          if (ln_j) begin
            j_cnt_d = j_cnt_q + JW'(1);
            if (j_cnt_q + JW'(1) == JW'(J_BITS)) begin
              state_d = DONE;
            end
          end else begin
            state_d = ERR;
          end
        end
      end
      // Pulse states last one clock; strobes landing here are dropped
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      se0_cnt_q <= '0;
      j_cnt_q   <= '0;
      in_eop_q  <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      se0_cnt_q <= se0_cnt_d;
      j_cnt_q   <= j_cnt_d;
      in_eop_q  <= (state_d == SE0) || (state_d == J_CHK);
      valid_q   <= (state_d == DONE);
      err_q     <= (state_d == ERR);
    end
  end

endmodule

// File: tb/tb_usb_rx_eop_detect.sv
// Bench for usb_rx_eop_detect: directed and random line-symbol
// streams against a sequence-level EOP model, two J_BITS configs.
`timescale 1ns/1ps
module tb_usb_rx_eop_detect;

  localparam logic [1:0] S_SE0 = 2'b00;
  localparam logic [1:0] S_J   = 2'b10;
  localparam logic [1:0] S_K   = 2'b01;
  localparam logic [1:0] S_SE1 = 2'b11;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic dp = 1'b1;
  logic dm = 1'b0;
  logic se = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [1:0] syms [64];
  int         n_sym = 0;
  logic       e_in  [2][64];
  logic       e_v   [2][64];
  logic       e_e   [2][64];
  int         e_cnt [2][64];
  int         cnt_m [2];

  always #5 clk = ~clk;

  usb_rx_eop_detect_if #(.CNT_W(3)) bus0 ();
  usb_rx_eop_detect_if #(.CNT_W(3)) bus1 ();

  assign bus0.d_plus_sync  = dp;
  assign bus0.d_minus_sync = dm;
  assign bus0.shift_en     = se;
  assign bus1.d_plus_sync  = dp;
  assign bus1.d_minus_sync = dm;
  assign bus1.shift_en     = se;

  usb_rx_eop_detect #(.SE0_MIN(2), .SE0_MAX(4), .J_BITS(1)) dut0 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus0)
  );

  usb_rx_eop_detect #(.SE0_MIN(2), .SE0_MAX(4), .J_BITS(2)) dut1 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus1)
  );

  task automatic chk(input string tag, input int idx,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step %0d observed %0h expected %0h",
             tag, idx, obs, exp);
    end
  endtask

  task automatic put(input int inst, input int idx, input logic i_in,
                     input logic i_v, input logic i_e, input int c);
    e_in[inst][idx]  = i_in;
    e_v[inst][idx]   = i_v;
    e_e[inst][idx]   = i_e;
    e_cnt[inst][idx] = c;
  endtask

  // Parse the symbol stream as runs: SE0 run length, then J trailer.
  task automatic model(input int inst, input int smin,
                       input int smax, input int jb);
    int i, r, d, m, c;
    i = 0;
    c = cnt_m[inst];
    while (i < n_sym) begin
      if (syms[i] != S_SE0) begin
        put(inst, i, 1'b0, 1'b0, 1'b0, c);
        i++;
      end else begin
        r = 0;
        while (i + r < n_sym && syms[i+r] == S_SE0 && r < smax) r++;
        for (int j = 0; j < r; j++) put(inst, i+j, 1'b1, 1'b0, 1'b0, j+1);
        c = r;
        d = i + r;
        if (r == smax) begin
          put(inst, d-1, 1'b0, 1'b0, 1'b1, smax);
          i = d;
        end else if (d >= n_sym) begin
          i = d;
        end else if (syms[d] != S_J || r < smin) begin
          put(inst, d, 1'b0, 1'b0, 1'b1, c);
          i = d + 1;
        end else begin
          m = 1;
          while (m < jb && d + m < n_sym && syms[d+m] == S_J) m++;
          for (int j = 0; j < m; j++) put(inst, d+j, 1'b1, 1'b0, 1'b0, c);
          if (m == jb) begin
            put(inst, d+jb-1, 1'b0, 1'b1, 1'b0, c);
            i = d + jb;
          end else if (d + m >= n_sym) begin
            i = d + m;
          end else begin
            put(inst, d+m, 1'b0, 1'b0, 1'b1, c);
            i = d + m + 1;
          end
        end
      end
    end
    cnt_m[inst] = c;
  endtask

  task automatic add(input logic [1:0] s);
    syms[n_sym] = s;
    n_sym++;
  endtask

  task automatic strobe(input int i);
    @(negedge clk);
    dp = syms[i][1];
    dm = syms[i][0];
    se = 1'b1;
    @(negedge clk);
    se = 1'b0;
    chk("eop0", i, bus0.eop, syms[i] == S_SE0);
    chk("eop1", i, bus1.eop, syms[i] == S_SE0);
    chk("in_eop0", i, bus0.in_eop, e_in[0][i]);
    chk("in_eop1", i, bus1.in_eop, e_in[1][i]);
    chk("valid0", i, bus0.eop_valid, e_v[0][i]);
    chk("valid1", i, bus1.eop_valid, e_v[1][i]);
    chk("err0", i, bus0.eop_err, e_e[0][i]);
    chk("err1", i, bus1.eop_err, e_e[1][i]);
    chk("cnt0", i, bus0.se0_cnt, e_cnt[0][i]);
    chk("cnt1", i, bus1.se0_cnt, e_cnt[1][i]);
    @(negedge clk);
    chk("valid_off0", i, bus0.eop_valid, 1'b0);
    chk("valid_off1", i, bus1.eop_valid, 1'b0);
    chk("err_off0", i, bus0.eop_err, 1'b0);
    chk("err_off1", i, bus1.eop_err, 1'b0);
    repeat (5) @(negedge clk);
  endtask

  task automatic go();
    model(0, 2, 4, 1);
    model(1, 2, 4, 2);
    for (int i = 0; i < n_sym; i++) strobe(i);
    n_sym = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in0"}, 0, bus0.in_eop, 1'b0);
    chk({tag, "_in1"}, 0, bus1.in_eop, 1'b0);
    chk({tag, "_v0"}, 0, bus0.eop_valid, 1'b0);
    chk({tag, "_v1"}, 0, bus1.eop_valid, 1'b0);
    chk({tag, "_e0"}, 0, bus0.eop_err, 1'b0);
    chk({tag, "_e1"}, 0, bus1.eop_err, 1'b0);
    chk({tag, "_c0"}, 0, bus0.se0_cnt, 0);
    chk({tag, "_c1"}, 0, bus1.se0_cnt, 0);
  endtask

  initial begin
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    chk("reset_eop", 0, bus0.eop, 1'b0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // good EOP, then one-bit SE0
    add(S_SE0); add(S_SE0); add(S_J); add(S_J); add(S_J);
    go();
    add(S_SE0); add(S_J); add(S_J); add(S_J);
    go();
    // over-long SE0 then restart
    add(S_SE0); add(S_SE0); add(S_SE0); add(S_SE0); add(S_SE0);
    add(S_J); add(S_J);
    go();
    // K / SE1 inside, J then K
    add(S_SE0); add(S_SE0); add(S_K); add(S_J); add(S_J);
    go();
    add(S_SE0); add(S_SE0); add(S_SE1); add(S_J); add(S_J);
    go();
    add(S_SE0); add(S_SE0); add(S_J); add(S_K); add(S_J); add(S_J);
    go();
    add(S_SE0); add(S_SE0); add(S_J); add(S_J); add(S_J);
    go();

    // lines at SE0 without strobes
    @(negedge clk);
    dp = 1'b0;
    dm = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("hold_eop", k, bus0.eop, 1'b1);
      chk("hold_in", k, bus0.in_eop, 1'b0);
      chk("hold_v", k, bus0.eop_valid | bus1.eop_valid, 1'b0);
      chk("hold_e", k, bus0.eop_err | bus1.eop_err, 1'b0);
      chk("hold_cnt", k, bus0.se0_cnt, cnt_m[0]);
    end
    dp = 1'b1;

    // reset in the middle of an EOP
    add(S_SE0);
    model(0, 2, 4, 1);
    model(1, 2, 4, 2);
    strobe(0);
    n_sym = 0;
    dp = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    chk_zero("mid_rst");
    chk("mid_rst_eop", 0, bus1.eop, 1'b1);
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    repeat (2) @(negedge clk);
    dp = 1'b1;
    n_rst = 1'b1;
    @(negedge clk);
    add(S_SE0); add(S_SE0); add(S_J); add(S_J); add(S_J);
    go();

    // random streams
    for (int t = 0; t < 30; t++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) begin
        int r;
        r = $urandom_range(0, 9);
        if (r < 5) add(S_SE0);
        else if (r < 8) add(S_J);
        else if (r == 8) add(S_K);
        else add(S_SE1);
      end
      add(S_J); add(S_J); add(S_J);
      go();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
